// File: rtl/tone_pkg.sv
// tone_pkg: shared types and helpers for the stereo tone NCO.
//   mode_e   : waveform select (saw, square, triangle, silence)
//   state_e  : sample-issue FSM states
//   MIDSCALE : offset-binary zero level for a given sample width
package tone_pkg;

  typedef enum logic [1:0] {
    MODE_SAW     = 2'd0,
    MODE_SQUARE  = 2'd1,
    MODE_TRI     = 2'd2,
    MODE_SILENCE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ISSUE = 2'd2,
    GAP   = 2'd3
  } state_e;

  function automatic logic [31:0] MIDSCALE(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/tone_wave_shaper.sv
// tone_wave_shaper: combinational phase -> sample shaper, one per channel.
// Optional build macro: TONE_GAIN_EN (adds 8-bit gain, out = (wave*gain)>>8).
// Ports:
//   phase_top [AUDIO_BITS:0] : top AUDIO_BITS+1 bits of the phase accumulator
//   mode                     : waveform select
//   gain [7:0]               : output scale (TONE_GAIN_EN only)
//   wave [AUDIO_BITS-1:0]    : unsigned offset-binary sample
module tone_wave_shaper
  import tone_pkg::*;
#(
  parameter int AUDIO_BITS = 12
) (
  input  logic [AUDIO_BITS:0]   phase_top,
  input  mode_e                 mode,
`ifdef TONE_GAIN_EN
  input  logic [7:0]            gain,
`endif
  output logic [AUDIO_BITS-1:0] wave
);

  localparam logic [AUDIO_BITS-1:0] MID = AUDIO_BITS'(MIDSCALE(AUDIO_BITS));

  logic                  msb;
  logic [AUDIO_BITS-1:0] t, u, raw;

  // t is the top slice (saw), u is the slice one bit lower; folding u on the
  // MSB gives a triangle of twice the slope with the same period.
  assign msb = phase_top[AUDIO_BITS];
  assign t   = phase_top[AUDIO_BITS:1];
  assign u   = phase_top[AUDIO_BITS-1:0];

  always_comb begin
    raw = MID;
    case (mode)
      MODE_SAW:     raw = t;
      MODE_SQUARE:  raw = {AUDIO_BITS{msb}};
      MODE_TRI:     raw = msb ? ~u : u;
      default:      raw = MID;
    endcase
  end

`ifdef TONE_GAIN_EN
  logic [AUDIO_BITS+7:0] prod;
  assign prod = {8'd0, raw} * {{AUDIO_BITS{1'b0}}, gain};
  assign wave = prod[AUDIO_BITS+7:8];
`else
  assign wave = raw;
`endif

endmodule

// File: rtl/tone_nco_stereo.sv
// tone_nco_stereo: stereo phase-accumulator tone source feeding the
// audio_44_1kHz sink via wreq/sample/ready, clk_audio domain.
// Optional build macro: TONE_GAIN_EN (adds gain input, shared by both channels).
// Ports:
//   clk, aclr_       : audio clock, async active-low reset
//   enable           : run/stop sample generation
//   ready            : sink can accept a sample
//   tune_l, tune_r   : per-channel phase increment per sample
//   mode             : 0 saw, 1 square, 2 triangle, 3 silence
//   cfg_load         : capture tune_l/tune_r/mode into pending registers
//   gain             : 8-bit output scale (TONE_GAIN_EN only)
//   wreq             : one-cycle write strobe
//   sample           : {left, right}, registered, valid while wreq=1
//   status           : toggles on every left-accumulator wrap
module tone_nco_stereo
  import tone_pkg::*;
#(
  parameter int AUDIO_BITS = 12,
  parameter int PHASE_BITS = 24
) (
  input  logic                    clk,
  input  logic                    aclr_,
  input  logic                    enable,
  input  logic                    ready,
  input  logic [PHASE_BITS-1:0]   tune_l,
  input  logic [PHASE_BITS-1:0]   tune_r,
  input  logic [1:0]              mode,
  input  logic                    cfg_load,
`ifdef TONE_GAIN_EN
  input  logic [7:0]              gain,
`endif
  output logic                    wreq,
  output logic [2*AUDIO_BITS-1:0] sample,
  output logic                    status
);

  state_e                  state, state_nxt;
  logic [PHASE_BITS-1:0]   phase_l, phase_r;
  logic [PHASE_BITS-1:0]   pend_tl, pend_tr, act_tl, act_tr;
  mode_e                   pend_mode, act_mode;
  logic [PHASE_BITS:0]     sum_l;
  logic [PHASE_BITS-1:0]   sum_r;
  logic [AUDIO_BITS-1:0]   wave_l, wave_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ARM;
      ARM:     if (!enable) state_nxt = IDLE;
               else if (ready) state_nxt = ISSUE;
      ISSUE:   state_nxt = GAP;
      default: state_nxt = ARM;
    endcase
  end

  // Left sum keeps its carry: that carry is the wrap event behind status.
  assign sum_l = {1'b0, phase_l} + {1'b0, act_tl};
  assign sum_r = phase_r + act_tr;

  tone_wave_shaper #(.AUDIO_BITS(AUDIO_BITS)) u_shape_l (
    .phase_top (phase_l[PHASE_BITS-1 -: AUDIO_BITS+1]),
    .mode      (act_mode),
`ifdef TONE_GAIN_EN
    .gain      (gain),
`endif
    .wave      (wave_l)
  );

  tone_wave_shaper #(.AUDIO_BITS(AUDIO_BITS)) u_shape_r (
    .phase_top (phase_r[PHASE_BITS-1 -: AUDIO_BITS+1]),
    .mode      (act_mode),
`ifdef TONE_GAIN_EN
    .gain      (gain),
`endif
    .wave      (wave_r)
  );

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      state     <= IDLE;
      wreq      <= 1'b0;
      sample    <= '0;
      status    <= 1'b0;
      phase_l   <= '0;
      phase_r   <= '0;
      pend_tl   <= '0;
      pend_tr   <= '0;
      act_tl    <= '0;
      act_tr    <= '0;
      pend_mode <= MODE_SAW;
      act_mode  <= MODE_SAW;
    end else begin
      state <= state_nxt;
      wreq  <= (state_nxt == ISSUE);
      // Sample is taken from the phase before this issue's advance.
      if (state_nxt == ISSUE) sample <= {wave_l, wave_r};
      if (state == ISSUE) begin
        phase_l <= sum_l[PHASE_BITS-1:0];
        phase_r <= sum_r;
        if (sum_l[PHASE_BITS]) status <= ~status;
      end
      if (cfg_load) begin
        pend_tl   <= tune_l;
        pend_tr   <= tune_r;
        pend_mode <= mode_e'(mode);
      end
      // Promotion only in GAP: the sample in flight never sees a mid-sample
      // config change, and the next advance uses the new increment.
      if (state == GAP) begin
        act_tl   <= pend_tl;
        act_tr   <= pend_tr;
        act_mode <= pend_mode;
      end
    end
  end

endmodule
